// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: EX forwarding selects, stall/flush for every pipeline register, memory-wait watchdog, perf counters.
// Controls are combinational (0 cycles); counters/watchdog are registered (1 cycle). A memory wait stalls everything upstream of WB.
module pipeline_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int FWD_EN      = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_e,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic              resultsrc_e,
    input  logic              pcsrc_e,
    input  logic              mem_req_m,
    input  logic              mem_ready_m,
    input  logic              perf_clr,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              memwait, load_use, raw_nofwd;

    // x0 never carries a real dependency, and a producer only counts if it writes.
    function automatic logic hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst,
                                 input logic we);
        return we && (src != '0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (hit(src, rd_m, regwrite_m))      return 2'b10;
        else if (hit(src, rd_w, regwrite_w)) return 2'b01;
        else                                 return 2'b00;
    endfunction

    assign memwait  = mem_req_m & ~mem_ready_m;
    assign load_use = resultsrc_e & (hit(rs1_d, rd_e, regwrite_e) | hit(rs2_d, rd_e, regwrite_e));
    assign raw_nofwd = (FWD_EN == 0) &&
                       (hit(rs1_d, rd_e, regwrite_e) || hit(rs2_d, rd_e, regwrite_e) ||
                        hit(rs1_d, rd_m, regwrite_m) || hit(rs2_d, rd_m, regwrite_m) ||
                        hit(rs1_d, rd_w, regwrite_w) || hit(rs2_d, rd_w, regwrite_w));

    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        if (rst) begin
            if (FWD_EN != 0) begin
                forward_a_e = fwd_sel(rs1_e);
                forward_b_e = fwd_sel(rs2_e);
            end
            // A branch resolved during a memory wait stays in E and is acted on once the wait ends.
            if (memwait) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (pcsrc_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use || raw_nofwd) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_comb begin
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q | (wait_cnt_q == TIMEOUT_V);
        if (memwait) begin
            wait_cnt_d = (wait_cnt_q == TIMEOUT_V) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_d && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
